// File: rtl/cam_capture_pkg.sv
// Shared types for the camera capture front end:
// FSM states, decimation codes and stream beat tag.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    DRAIN
  } cap_state_e;

  localparam logic [1:0] DEC_X1 = 2'b00;
  localparam logic [1:0] DEC_D2 = 2'b01;
  localparam logic [1:0] DEC_D4 = 2'b10;

  localparam int HDR_TYPE = 0;

  typedef struct packed {
    logic sop;
    logic eop;
  } beat_tag_t;

  function automatic logic [2:0] dec_step(input logic [1:0] dec);
    unique case (dec)
      DEC_D2:  return 3'd2;
      DEC_D4:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO with a registered output slot;
// count/free include the beat held at the output.
module sync_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   free_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   mcnt_q, mcnt_d;
  logic [W-1:0]  dout_q;
  logic          vld_q;
  logic          pop, load;

  assign pop  = vld_q & rd_i;
  assign load = (mcnt_q != '0) & (!vld_q | pop);

  always_comb begin
    mcnt_d = mcnt_q;
    unique case ({wr_i, load})
      2'b10:   mcnt_d = mcnt_q + 1'b1;
      2'b01:   mcnt_d = mcnt_q - 1'b1;
      default: mcnt_d = mcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      mcnt_q <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
      if (wr_i) wp_q <= wp_q + 1'b1;
      if (load) begin
        rp_q   <= rp_q + 1'b1;
        dout_q <= mem_q[rp_q];
        vld_q  <= 1'b1;
      end else if (pop) begin
        vld_q  <= 1'b0;
      end
    end
  end

  // Storage has no reset; a read never targets the slot written this edge.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wp_q] <= wdata_i;
  end

  assign rdata_o = dout_q;
  assign valid_o = vld_q;
  assign count_o = mcnt_q + {{AW{1'b0}}, vld_q};
  assign free_o  = (AW+1)'(DEPTH) - count_o;

endmodule

// File: rtl/cam_stream_capture.sv
// Camera pixel capture: FVAL/LVAL qualify, crop, decimate,
// and emit Avalon-ST Video packets through a show-ahead FIFO.
module cam_stream_capture #(
  parameter int PIX_W      = 12,
  parameter int CNT_W      = 12,
  parameter int FIFO_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] cam_d,
  input  logic             cam_fval,
  input  logic             cam_lval,
  input  logic             cfg_enable,
  input  logic [CNT_W-1:0] cfg_x0,
  input  logic [CNT_W-1:0] cfg_y0,
  input  logic [CNT_W-1:0] cfg_w,
  input  logic [CNT_W-1:0] cfg_h,
  input  logic [1:0]       cfg_dec,
  output logic [PIX_W-1:0] src_data,
  output logic             src_valid,
  input  logic             src_ready,
  output logic             src_sop,
  output logic             src_eop,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_dropped,
  output logic             stat_overflow,
  input  logic             stat_clear
);
  import cam_capture_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = CNT_W + 1;
  localparam int BW = PIX_W + 2;

  typedef struct packed {
    beat_tag_t        tag;
    logic [PIX_W-1:0] data;
  } beat_t;

  cap_state_e       state_q, state_d;
  logic [PIX_W-1:0] d_q;
  logic             fv_q, lv_q, fval_q, lvp_q;
  logic             sof, qual, lrise, lfall;
  logic [XW-1:0]    x_q, y_q, x_cur;
  logic [XW-1:0]    x0_q, y0_q, w_q, h_q;
  logic [1:0]       dec_q;
  logic [XW-1:0]    dx, dy, step, mask;
  logic             keep, last;
  logic             wr, latch, frm_inc, drp_inc, ovf_set;
  beat_t            wbeat, rbeat;
  logic [BW-1:0]    rdata;
  logic [AW:0]      fifo_cnt, fifo_free;
  logic             no_room;
  logic [15:0]      frames_q, dropped_q;
  logic             ovf_q;

  // fval_q resets high so a frame already running at release is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= '0;
      fv_q   <= 1'b1;
      lv_q   <= 1'b0;
      fval_q <= 1'b1;
      lvp_q  <= 1'b0;
    end else begin
      d_q    <= cam_d;
      fv_q   <= cam_fval;
      lv_q   <= cam_lval;
      fval_q <= fv_q;
      lvp_q  <= lv_q;
    end
  end

  assign sof   = fv_q & !fval_q;
  assign qual  = fv_q & lv_q;
  assign lrise = lv_q & !lvp_q;
  assign lfall = !lv_q & lvp_q;
  assign x_cur = lrise ? '0 : x_q;

  always_ff @(posedge clk) begin
    if (reset || sof) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (qual) x_q <= x_cur + 1'b1;
      if (lfall) y_q <= y_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q  <= '0;
      y0_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      dec_q <= DEC_X1;
    end else if (latch) begin
      x0_q  <= {1'b0, cfg_x0};
      y0_q  <= {1'b0, cfg_y0};
      w_q   <= {1'b0, cfg_w};
      h_q   <= {1'b0, cfg_h};
      dec_q <= cfg_dec;
    end
  end

  assign dx   = x_cur - x0_q;
  assign dy   = y_q - y0_q;
  assign step = XW'(dec_step(dec_q));
  assign mask = step - 1'b1;
  assign keep = qual
              && (x_cur >= x0_q) && (x_cur < x0_q + w_q)
              && (y_q >= y0_q) && (y_q < y0_q + h_q)
              && ((dx & mask) == '0) && ((dy & mask) == '0);
  assign last = (dx + step >= w_q) && (dy + step >= h_q);

  // The last free slot is held back for a packet terminator.
  assign no_room = (fifo_free < (AW+1)'(2))
                || (fifo_cnt >= (AW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wr         = 1'b0;
    wbeat      = '0;
    latch      = 1'b0;
    frm_inc    = 1'b0;
    drp_inc    = 1'b0;
    ovf_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (sof) begin
          latch = 1'b1;
          if (cfg_w != '0 && cfg_h != '0) begin
            if (no_room) begin
              drp_inc = 1'b1;
            end else begin
              wr            = 1'b1;
              wbeat.tag.sop = 1'b1;
              wbeat.data    = PIX_W'(HDR_TYPE);
              state_d       = ACTIVE;
            end
          end
        end
      end
      ACTIVE: begin
        if (!fv_q) begin
          wr            = 1'b1;
          wbeat.tag.eop = 1'b1;
          drp_inc       = 1'b1;
          state_d       = WAIT_SOF;
        end else if (keep) begin
          wr = 1'b1;
          if (no_room) begin
            wbeat.tag.eop = 1'b1;
            ovf_set       = 1'b1;
            drp_inc       = 1'b1;
            state_d       = DRAIN;
          end else begin
            wbeat.tag.eop = last;
            wbeat.data    = d_q;
            if (last) begin
              frm_inc = 1'b1;
              state_d = WAIT_SOF;
            end
          end
        end
      end
      DRAIN: begin
        if (!fv_q) state_d = WAIT_SOF;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      frames_q  <= '0;
      dropped_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (frm_inc) frames_q <= frames_q + 1'b1;
      if (drp_inc) dropped_q <= dropped_q + 1'b1;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (wr),
    .wdata_i (wbeat),
    .rd_i    (src_ready),
    .rdata_o (rdata),
    .valid_o (src_valid),
    .count_o (fifo_cnt),
    .free_o  (fifo_free)
  );

  assign rbeat         = rdata;
  assign src_data      = rbeat.data;
  assign src_sop       = rbeat.tag.sop;
  assign src_eop       = rbeat.tag.eop;
  assign stat_frames   = frames_q;
  assign stat_dropped  = dropped_q;
  assign stat_overflow = ovf_q;

endmodule
